// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller.
// Holds the SPECIAL and SPECIAL2 funct codes, the internal operation
// encoding, and small helpers for decode and operation classification.
package mult_div_ctrl_pkg;

  // SPECIAL (special2 = 0) funct codes
  localparam logic [5:0] FUNCT_MULT   = 6'h18;
  localparam logic [5:0] FUNCT_MULTU  = 6'h19;
  localparam logic [5:0] FUNCT_DIV    = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU   = 6'h1b;

  // SPECIAL2 (special2 = 1) funct codes
  localparam logic [5:0] FUNCT2_MADD  = 6'h00;
  localparam logic [5:0] FUNCT2_MADDU = 6'h01;
  localparam logic [5:0] FUNCT2_MUL   = 6'h02;
  localparam logic [5:0] FUNCT2_MSUB  = 6'h04;
  localparam logic [5:0] FUNCT2_MSUBU = 6'h05;

  typedef enum logic [3:0] {
    OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_MUL, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
  } md_op_e;

  function automatic md_op_e decode_op(input logic special2, input logic [5:0] funct);
    md_op_e op;
    op = OP_NONE;
    if (!special2) begin
      case (funct)
        FUNCT_MULT:  op = OP_MULT;
        FUNCT_MULTU: op = OP_MULTU;
        FUNCT_DIV:   op = OP_DIV;
        FUNCT_DIVU:  op = OP_DIVU;
        default:     op = OP_NONE;
      endcase
    end else begin
      case (funct)
        FUNCT2_MADD:  op = OP_MADD;
        FUNCT2_MADDU: op = OP_MADDU;
        FUNCT2_MUL:   op = OP_MUL;
        FUNCT2_MSUB:  op = OP_MSUB;
        FUNCT2_MSUBU: op = OP_MSUBU;
        default:      op = OP_NONE;
      endcase
    end
    return op;
  endfunction

  function automatic logic op_is_div(input md_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MUL) ||
           (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/div_core.sv
// Iterative restoring divider, one quotient bit per cycle, 32 cycles.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start                load dividend/divisor and begin iterating
//   abort                drop any iteration in progress (priority over start)
//   dividend, divisor    unsigned operands (divisor must be non-zero)
//   quotient, remainder  result of the current step; final when valid=1
//   valid                high during the last iteration cycle
module div_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        valid
);
  localparam int unsigned ITERS = 32;
  localparam int unsigned CNT_W = 6;

  logic [31:0]      quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [32:0]      shifted, diff;
  logic [31:0]      step_quo, step_rem;
  logic             last;

  always_comb begin
    // Dividend bits shift out of quo_q into the partial remainder while
    // quotient bits shift in from the bottom.
    shifted  = {rem_q, quo_q[31]};
    diff     = shifted - {1'b0, dvs_q};
    step_rem = diff[32] ? shifted[31:0] : diff[31:0];
    step_quo = {quo_q[30:0], ~diff[32]};
    last     = (cnt_q == CNT_W'(ITERS - 1));

    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    run_d = run_q;

    if (abort) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      quo_d = step_quo;
      rem_d = step_rem;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) begin
        run_d = 1'b0;
      end
    end
  end

  assign valid     = run_q && last && !abort;
  assign quotient  = step_quo;
  assign remainder = step_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// EX-stage multiply/divide controller: MULT/MULTU/DIV/DIVU and the
// SPECIAL2 MUL/MADD(U)/MSUB(U) group. Multiplies finish two cycles after
// start, divides 33 cycles after start (divide-by-zero after one).
// Ports:
//   clk, rst_n             clock, async active-low reset
//   en                     EX instruction valid and not squashed
//   funct, special2        opcode selection
//   operand_1, operand_2   rs, rt
//   hi_i, lo_i             current HI/LO for accumulate forms
//   pipe_stall             downstream stall; holds the DONE state
//   flush                  pipeline flush; aborts to IDLE
//   done                   result valid (DONE state)
//   result                 {hi, lo}
//   busy                   state is not IDLE
module mult_div_ctrl
  import mult_div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [5:0]  funct,
  input  logic        special2,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        pipe_stall,
  input  logic        flush,
  output logic        done,
  output logic [63:0] result,
  output logic        busy
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  md_op_e      op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [63:0] hilo_q, hilo_d;
  logic [63:0] result_q, result_d;

  md_op_e      op_in;
  logic        start, in_signed, div_start;
  logic [31:0] mag_a, mag_b;
  logic        div_valid;
  logic [31:0] div_quo, div_rem;
  logic [63:0] ext_a, ext_b, prod, mul_res;
  logic        sgn_q;
  logic [31:0] q_fix, r_fix;

  assign op_in     = decode_op(special2, funct);
  assign start     = en && (state_q == ST_IDLE) && (op_in != OP_NONE) && !flush;
  assign in_signed = op_is_signed(op_in);
  assign mag_a     = (in_signed && operand_1[31]) ? (32'd0 - operand_1) : operand_1;
  assign mag_b     = (in_signed && operand_2[31]) ? (32'd0 - operand_2) : operand_2;
  assign div_start = start && op_is_div(op_in) && (operand_2 != 32'd0);

  div_core u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .abort     (flush),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  always_comb begin
    sgn_q   = op_is_signed(op_q);
    ext_a   = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    ext_b   = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    // Low 64 bits of the extended product are exact for both signednesses.
    prod    = ext_a * ext_b;
    mul_res = prod;
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = hilo_q + prod;
      OP_MSUB, OP_MSUBU: mul_res = hilo_q - prod;
      default:           mul_res = prod;
    endcase
    // Quotient negated on sign mismatch; remainder follows the dividend.
    q_fix = (sgn_q && (a_q[31] ^ b_q[31])) ? (32'd0 - div_quo) : div_quo;
    r_fix = (sgn_q && a_q[31]) ? (32'd0 - div_rem) : div_rem;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hilo_d   = hilo_q;
    result_d = result_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_d   = op_in;
            a_d    = operand_1;
            b_d    = operand_2;
            hilo_d = {hi_i, lo_i};
            if (op_is_div(op_in)) begin
              if (operand_2 == 32'd0) begin
                result_d = {operand_1, 32'hFFFF_FFFF};
                state_d  = ST_DONE;
              end else begin
                state_d = ST_DIV;
              end
            end else begin
              state_d = ST_MUL;
            end
          end
        end
        ST_MUL: begin
          result_d = mul_res;
          state_d  = ST_DONE;
        end
        ST_DIV: begin
          if (div_valid) begin
            result_d = {r_fix, q_fix};
            state_d  = ST_DONE;
          end
        end
        default: begin
          if (!pipe_stall) begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NONE;
      a_q      <= '0;
      b_q      <= '0;
      hilo_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hilo_q   <= hilo_d;
      result_q <= result_d;
    end
  end

  assign done   = (state_q == ST_DONE);
  assign busy   = (state_q != ST_IDLE);
  assign result = result_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: scoreboard of expected results
// and latencies, one task per scenario.
module tb_mult_div_ctrl;

  localparam logic [5:0] F_MULT  = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;
  localparam logic [5:0] F_MADD  = 6'h00, F_MADDU = 6'h01, F_MUL = 6'h02;
  localparam logic [5:0] F_MSUB  = 6'h04, F_MSUBU = 6'h05;

  logic        clk = 1'b0;
  logic        rst_n, en, special2, pipe_stall, flush;
  logic [5:0]  funct;
  logic [31:0] operand_1, operand_2, hi_i, lo_i;
  logic        done, busy;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  mult_div_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .funct      (funct),
    .special2   (special2),
    .operand_1  (operand_1),
    .operand_2  (operand_2),
    .hi_i       (hi_i),
    .lo_i       (lo_i),
    .pipe_stall (pipe_stall),
    .flush      (flush),
    .done       (done),
    .result     (result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_res(input logic [5:0] f, input logic sp2,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] hi, input logic [31:0] lo);
    longint      sp;
    logic [63:0] up, acc;
    int          sa, sbv, q, r;
    sp  = longint'(signed'(a)) * longint'(signed'(b));
    up  = 64'(a) * 64'(b);
    acc = {hi, lo};
    if (!sp2) begin
      if (f == F_MULT)  return sp;
      if (f == F_MULTU) return up;
      if (b == 32'd0)   return {a, 32'hFFFF_FFFF};
      if (f == F_DIVU)  return {a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa  = signed'(a);
      sbv = signed'(b);
      q   = sa / sbv;
      r   = sa % sbv;
      return {32'(r), 32'(q)};
    end
    case (f)
      F_MADD:  return acc + sp;
      F_MADDU: return acc + up;
      F_MSUB:  return acc - sp;
      F_MSUBU: return acc - up;
      default: return sp;
    endcase
  endfunction

  function automatic int model_lat(input logic [5:0] f, input logic sp2, input logic [31:0] b);
    if (!sp2 && (f == F_DIV || f == F_DIVU)) return (b == 32'd0) ? 1 : 33;
    return 2;
  endfunction

  function automatic void push_exp(input logic [5:0] f, input logic sp2,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.res = model_res(f, sp2, a, b, hi, lo);
    e.lat = model_lat(f, sp2, b);
    sbq.push_back(e);
  endfunction

  // Called #1 after a posedge. Returns at the negedge where done is first
  // seen (lat = cycles after the start edge), or lat = -1 on timeout.
  task automatic run_op(input logic [5:0] f, input logic sp2, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        output int lat, output logic [63:0] res);
    funct = f; special2 = sp2; operand_1 = a; operand_2 = b; hi_i = hi; lo_i = lo; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    operand_1 = $urandom; operand_2 = $urandom; hi_i = $urandom; lo_i = $urandom;
    lat = -1;
    res = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_mult;
    int lat; logic [63:0] res; exp_t e;
    push_exp(F_MULT, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0);
    run_op(F_MULT, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, lat, res);
    e = sbq.pop_front();
    checks++; if (lat !== 2) begin errors++; $display("FAIL mult_latency: got %0d expected 2", lat); end
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFA || res !== e.res)
      begin errors++; $display("FAIL mult_result: got %h expected %h", res, e.res); end
    @(posedge clk); #1;
  endtask

  task automatic test_maddu;
    int lat; logic [63:0] res; exp_t e;
    push_exp(F_MADDU, 1'b1, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF);
    run_op(F_MADDU, 1'b1, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, lat, res);
    e = sbq.pop_front();
    checks++; if (lat !== 2) begin errors++; $display("FAIL maddu_latency: got %0d expected 2", lat); end
    checks++; if (res !== 64'h0000_0001_0000_0000)
      begin errors++; $display("FAIL maddu_result: got %h expected %h", res, e.res); end
    @(posedge clk); #1;
  endtask

  task automatic test_div;
    int lat; logic [63:0] res; exp_t e;
    push_exp(F_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
    run_op(F_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, lat, res);
    e = sbq.pop_front();
    checks++; if (lat !== e.lat || lat !== 33) begin errors++; $display("FAIL div_latency: got %0d expected %0d", lat, e.lat); end
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD)
      begin errors++; $display("FAIL div_result: got %h expected %h", res, e.res); end
    @(posedge clk); #1;
    push_exp(F_DIVU, 1'b0, 32'd7, 32'd0, 32'd0, 32'd0);
    run_op(F_DIVU, 1'b0, 32'd7, 32'd0, 32'd0, 32'd0, lat, res);
    e = sbq.pop_front();
    checks++; if (lat !== 1) begin errors++; $display("FAIL divu_zero_latency: got %0d expected 1", lat); end
    checks++; if (res !== 64'h0000_0007_FFFF_FFFF)
      begin errors++; $display("FAIL divu_zero_result: got %h expected %h", res, e.res); end
    @(posedge clk); #1;
  endtask

  task automatic test_variety;
    logic [5:0]  tf[10]; logic tsp[10];
    logic [31:0] ta[10], tb[10], th[10], tl[10];
    int lat; logic [63:0] res; exp_t e;
    tf = '{F_MULTU, F_MUL, F_MADD, F_MSUB, F_MSUBU, F_DIVU, F_DIV, F_DIV, F_DIV, F_MULT};
    tsp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ta = '{32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF,
           32'd100, 32'h8000_0000, 32'd7, 32'hFFFF_FFFB, $urandom};
    tb = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd1, 32'hFFFF_FFFE, 32'd2,
           32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, $urandom};
    th = '{32'd0, 32'd0, 32'h1, 32'h0, 32'h5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    tl = '{32'd0, 32'd0, 32'h0, 32'h10, 32'h0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 10; i++) begin
      push_exp(tf[i], tsp[i], ta[i], tb[i], th[i], tl[i]);
      run_op(tf[i], tsp[i], ta[i], tb[i], th[i], tl[i], lat, res);
      e = sbq.pop_front();
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL variety_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
      checks++; if (res !== e.res) begin errors++; $display("FAIL variety_result[%0d]: got %h expected %h", i, res, e.res); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_non_op;
    logic seen;
    seen = 1'b0;
    en = 1'b1; special2 = 1'b0; funct = 6'h20;
    @(posedge clk); #1;
    special2 = 1'b1; funct = 6'h03;
    @(posedge clk); #1;
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy || done) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL non_op_idle: got busy/done=%b expected 0", seen); end
  endtask

  task automatic test_flush;
    logic [63:0] prev, res; logic seen; int lat; exp_t e;
    prev = result;
    seen = 1'b0;
    funct = F_DIVU; special2 = 1'b0; operand_1 = 32'd1000; operand_2 = 32'd3; en = 1'b1;
    @(posedge clk); #1;            // cycle T+1
    en = 1'b0;
    repeat (9) begin
      @(negedge clk); if (done) seen = 1'b1;
      @(posedge clk); #1;
    end                             // cycle T+10
    flush = 1'b1;
    @(negedge clk); if (done) seen = 1'b1;
    @(posedge clk); #1;            // cycle T+11
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle: busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0 || seen !== 1'b0) begin errors++; $display("FAIL flush_no_done: got %b expected 0", done | seen); end
    checks++; if (result !== prev) begin errors++; $display("FAIL flush_result_held: got %h expected %h", result, prev); end
    push_exp(F_MULTU, 1'b0, 32'h0001_0000, 32'h0003_0000, 32'd0, 32'd0);
    run_op(F_MULTU, 1'b0, 32'h0001_0000, 32'h0003_0000, 32'd0, 32'd0, lat, res);
    e = sbq.pop_front();
    checks++; if (lat !== 2) begin errors++; $display("FAIL flush_next_latency: got %0d expected 2", lat); end
    checks++; if (res !== e.res) begin errors++; $display("FAIL flush_next_result: got %h expected %h", res, e.res); end
    @(posedge clk); #1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk); if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_div_aborted: late done got %b expected 0", seen); end
  endtask

  task automatic test_stall;
    int lat, high, extra; logic [63:0] res; exp_t e;
    push_exp(F_MULTU, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 32'd0, 32'd0);
    run_op(F_MULTU, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 32'd0, 32'd0, lat, res);
    e = sbq.pop_front();
    checks++; if (res !== e.res || lat !== 2) begin errors++; $display("FAIL stall_result: got %h lat %0d expected %h lat 2", res, lat, e.res); end
    pipe_stall = 1'b1;
    high = 1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      if (i == 3) pipe_stall = 1'b0;
      @(negedge clk);
      if (done) high++;
      checks++; if (result !== e.res) begin errors++; $display("FAIL stall_result_stable[%0d]: got %h expected %h", i, result, e.res); end
    end
    checks++; if (high !== 4) begin errors++; $display("FAIL stall_done_cycles: got %0d expected 4", high); end
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL stall_single_completion: extra done cycles %0d expected 0", extra); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat; logic [63:0] res; exp_t e;
    push_exp(F_MULT, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0);
    push_exp(F_MULTU, 1'b0, 32'h8000_0001, 32'd5, 32'd0, 32'd0);
    run_op(F_MULT, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0, lat, res);
    e = sbq.pop_front();
    checks++; if (res !== e.res) begin errors++; $display("FAIL b2b_first_result: got %h expected %h", res, e.res); end
    // Request a new op while in DONE; it must only be taken once IDLE.
    funct = F_MULTU; special2 = 1'b0; operand_1 = 32'h8000_0001; operand_2 = 32'd5; en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_start_in_done: busy got %b expected 0", busy); end
    @(posedge clk); #1;
    en = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_second_mul: busy/done got %b%b expected 10", busy, done); end
    @(negedge clk);
    e = sbq.pop_front();
    checks++; if (done !== 1'b1 || result !== e.res) begin errors++; $display("FAIL b2b_second_result: done %b got %h expected %h", done, result, e.res); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic seen;
    funct = F_DIV; special2 = 1'b0; operand_1 = 32'd12345; operand_2 = 32'd17; en = 1'b1;
    @(posedge clk); #1;            // cycle T+1
    en = 1'b0;
    repeat (4) begin @(posedge clk); #1; end   // cycle T+5
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_mid_busy_before: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_mid_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b expected 0", busy); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_mid_result: got %h expected 0", result); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk); if (done || busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_after_release: busy/done got %b expected 0", seen); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; funct = '0; special2 = 1'b0;
    operand_1 = '0; operand_2 = '0; hi_i = '0; lo_i = '0;
    pipe_stall = 1'b0; flush = 1'b0;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_mult;
    test_maddu;
    test_div;
    test_variety;
    test_non_op;
    test_flush;
    test_stall;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, rising-edge clock; rst_n in 1, reset, asynchronous and active-low.
REQ-002 SHALL have en in 1: EX-stage instruction valid, not squashed.
REQ-003 SHALL have funct in 6 (`FUNCT_BUS`) and special2 in 1; special2=1 selects the FUNCT2_* decoding.
REQ-004 SHALL have operand_1 and operand_2, each in 32: rs and rt values.
REQ-005 SHALL have hi_i and lo_i, each in 32: current HI/LO for accumulate.
REQ-006 SHALL have pipe_stall in 1: EX is held by a downstream stall.
REQ-007 SHALL have flush in 1: exception/ERET pipeline flush.
REQ-008 SHALL have done out 1, which feeds EX mult_div_done.
REQ-009 SHALL have result out 64 ({hi,lo}), which feeds EX mult_div_result.
REQ-010 SHALL have busy out 1: state is not IDLE.

Function
REQ-011 States SHALL be IDLE, MUL, DIV, DONE.
REQ-012 start SHALL = en & IDLE & op in {MULT, MULTU, DIV, DIVU} (special2=0) or {MUL, MADD, MADDU, MSUB, MSUBU} (special2=1); other functs leave the block idle with done=0.
REQ-013 On start at cycle T, the block SHALL latch operands, op and hi_i/lo_i.
  - Multiply class: IDLE->MUL at T+1, ->DONE at T+2.
  - Divide class: IDLE->DIV at T+1 for exactly 32 iteration cycles, ->DONE at T+33.
REQ-014 Divide by zero SHALL go IDLE->DONE directly (T+1) with result = {operand_1, 32'hFFFFFFFF}.
REQ-015 MULT/MUL SHALL produce the signed 64-bit product; MULTU the unsigned product; MUL result[31:0] = low product word.
REQ-016 MADD/MADDU SHALL produce {hi,lo}+product, and MSUB/MSUBU {hi,lo}-product, mod 2^64, signedness per opcode.
REQ-017 DIV/DIVU SHALL place the quotient in result[31:0] and the remainder in result[63:32].
REQ-018 Signed divide SHALL run on magnitudes; quotient negated if signs differ, remainder takes the dividend's sign; 0x80000000 / -1 -> quotient 0x80000000, remainder 0.
REQ-019 done SHALL =1 only in DONE; result SHALL be stable whenever done=1 and held until the next start.
REQ-020 DONE->IDLE SHALL occur next cycle when pipe_stall=0; with pipe_stall=1, stay in DONE (done stays 1, no restart of the held instruction).
REQ-021 A start SHALL NOT be accepted in the DONE cycle; the earliest back-to-back start is the cycle after DONE.
REQ-022 flush=1 SHALL force state->IDLE at the next edge from any state, abort any iteration, leave result unchanged, and give done=0 from that edge; flush has priority over start and completion.
REQ-023 en=0 mid-operation (without flush) SHALL NOT abort.

Reset
REQ-024 rst_n low SHALL immediately set state=IDLE, done=0, busy=0, result=64'h0, and clear the divider iteration count and working registers.
REQ-025 Release of rst_n SHALL be followed by IDLE with no spurious done.

Structure
REQ-026 Funct codes SHALL come from the shared funct include; state encoding and the iteration count 32 SHALL be local constants.
REQ-027 The iterative restoring divider SHALL be the sub-module div_core (start, unsigned dividend/divisor in, quotient/remainder/valid out); sign fix-up and multiply stay in mult_div_ctrl.

Verification
REQ-028 MULT, op1=0xFFFFFFFE (-2), op2=3 at T -> done at T+2, result=0xFFFFFFFF_FFFFFFFA.
REQ-029 MADDU, hi/lo=0x0:0xFFFFFFFF, op1=op2=1 -> done at T+2, result=0x00000001_00000000.
REQ-030 DIV, op1=-7, op2=2 -> done at T+33, result={0xFFFFFFFF, 0xFFFFFFFD}; DIVU 7/0 -> done at T+1, result={7, 0xFFFFFFFF}.
REQ-031 DIVU started, flush at T+10 -> done never asserts, IDLE at T+11; a new MULTU at T+11 completes at T+13.
REQ-032 MULTU with pipe_stall=1 for 3 cycles at DONE -> done high 4 cycles, result constant, one completion only.
REQ-033 rst_n asserted at T+5 of DIV -> outputs zero immediately; after release IDLE, no done.
